multicycle_control_unit: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives per-cycle datapath enables.
- Handshakes with a shared instruction/data memory via req/ready, with a parametrised timeout watchdog.
- Sits between the instruction register (opcode/funcode) and the multi-cycle datapath; one instance per core.

---
 rtl/multicycle_control_unit_pkg.sv | 89 ++++++++
 rtl/mcu_mem_watchdog.sv | 29 ++
 rtl/multicycle_control_unit.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared control constants for the multi-cycle MIPS core:
// opcodes, ALU codes, FSM state codes and datapath select values.
package multicycle_control_unit_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SRAV  = 6'b000111;

   localparam logic [3:0] ALU_NONE = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SRAV = 4'b1010;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_EXEC_R   = 4'd2;
   localparam logic [3:0] S_WB_R     = 4'd3;
   localparam logic [3:0] S_EXEC_I   = 4'd4;
   localparam logic [3:0] S_WB_I     = 4'd5;
   localparam logic [3:0] S_MEM_ADDR = 4'd6;
   localparam logic [3:0] S_MEM_RD   = 4'd7;
   localparam logic [3:0] S_WB_MEM   = 4'd8;
   localparam logic [3:0] S_MEM_WR   = 4'd9;
   localparam logic [3:0] S_BRANCH   = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;
   localparam logic [3:0] S_TRAP     = 4'd12;

   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_LUI  = 2'b10;

   typedef struct packed {
      logic       memReq;
      logic       memWrite;
      logic       iOrD;
      logic       irWrite;
      logic       pcWrite;
      logic [1:0] pcSource;
      logic       regWrite;
      logic       waControl;
      logic       wdControl;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [3:0] aluControl;
      logic [1:0] signExt;
   } ctrl_t;

   function automatic logic [3:0] dispatch(
      input logic [5:0] op,
      input logic [5:0] fn
   );
      logic [3:0] nxt;
      logic       isR;
      isR = (op == OP_RTYPE);
      nxt = S_TRAP;
      unique case (1'b1)
         isR && (fn == FN_ADD || fn == FN_SRAV):
            nxt = S_EXEC_R;
         op == OP_ADDI || op == OP_ADDIU || op == OP_LUI:
            nxt = S_EXEC_I;
         op == OP_LW || op == OP_SW:
            nxt = S_MEM_ADDR;
         op == OP_BEQ:
            nxt = S_BRANCH;
         op == OP_J:
            nxt = S_JUMP;
         default:
            nxt = S_TRAP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mcu_mem_watchdog.sv
// Memory-wait watchdog: counts stalled request cycles and
// flags a timeout on the cycle the count would hit TIMEOUT.
module mcu_mem_watchdog #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic memReq,
   input  logic memReady,
   output logic timeout
);

   logic [CNT_W-1:0] cnt;
   logic             waiting;

   assign waiting = memReq && !memReady;
   assign timeout = (TIMEOUT != 0) && waiting
                 && (cnt == CNT_W'(TIMEOUT - 1));

   // Dropping memReq means the memory state was left.
   always_ff @(posedge clk) begin
      if (rst || !memReq || memReady || timeout)
         cnt <= '0;
      else if (waiting)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/
// memory/writeback and drives per-cycle datapath enables.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int OP_W      = 6,
   parameter int ALUCTRL_W = 4,
   parameter int EXT_W     = 2,
   parameter int TIMEOUT   = 16,
   parameter int CNT_W     = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [OP_W-1:0]      opcode,
   input  logic [OP_W-1:0]      funcode,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_write,
   output logic                 i_or_d,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic [1:0]           pc_source,
   output logic                 reg_write,
   output logic                 wa_control,
   output logic                 wd_control,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [ALUCTRL_W-1:0] alu_control,
   output logic [EXT_W-1:0]     sign_ext_signal,
   output logic                 illegal,
   output logic                 bus_error,
   output logic [3:0]           busy_state
);

   logic [3:0] state;
   logic [3:0] nextState;
   logic       armed;
   logic       memReq;
   logic       timeout;
   ctrl_t      ctrl;

   // First cycle after reset is quiet so an abandoned
   // access is seen to drop before FETCH re-requests.
   assign memReq = armed && (state == S_FETCH
                          || state == S_MEM_RD
                          || state == S_MEM_WR);

   mcu_mem_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) uWatchdog (
      .clk      (clk),
      .rst      (rst),
      .memReq   (memReq),
      .memReady (mem_ready),
      .timeout  (timeout)
   );

   always_comb begin
      ctrl = '0;
      ctrl.aluControl = ALU_NONE;
      ctrl.memReq = memReq;
      nextState = state;
      if (armed) begin
         unique case (state)
            S_FETCH: begin
               ctrl.aluSrcB = SRCB_FOUR;
               ctrl.aluControl = ALU_ADD;
               if (mem_ready) begin
                  ctrl.irWrite = 1'b1;
                  ctrl.pcWrite = 1'b1;
                  ctrl.pcSource = PCSRC_ALU;
                  nextState = S_DECODE;
               end else if (timeout) begin
                  nextState = S_TRAP;
               end
            end
            S_DECODE: begin
               ctrl.aluSrcB = SRCB_IMMSH;
               ctrl.signExt = EXT_SIGN;
               ctrl.aluControl = ALU_ADD;
               nextState = dispatch(opcode, funcode);
            end
            S_EXEC_R: begin
               ctrl.aluSrcA = 1'b1;
               ctrl.aluSrcB = SRCB_RT;
               ctrl.aluControl = (funcode == FN_SRAV)
                               ? ALU_SRAV : ALU_ADD;
               nextState = S_WB_R;
            end
            S_WB_R: begin
               ctrl.regWrite = 1'b1;
               ctrl.waControl = 1'b1;
               nextState = S_FETCH;
            end
            S_EXEC_I: begin
               ctrl.aluSrcA = 1'b1;
               ctrl.aluSrcB = SRCB_IMM;
               ctrl.aluControl = ALU_ADD;
               ctrl.signExt = (opcode == OP_LUI)
                            ? EXT_LUI : EXT_SIGN;
               nextState = S_WB_I;
            end
            S_WB_I: begin
               ctrl.regWrite = 1'b1;
               nextState = S_FETCH;
            end
            S_MEM_ADDR: begin
               ctrl.aluSrcA = 1'b1;
               ctrl.aluSrcB = SRCB_IMM;
               ctrl.signExt = EXT_SIGN;
               ctrl.aluControl = ALU_ADD;
               nextState = (opcode == OP_SW)
                         ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               ctrl.iOrD = 1'b1;
               if (mem_ready)
                  nextState = S_WB_MEM;
               else if (timeout)
                  nextState = S_TRAP;
            end
            S_WB_MEM: begin
               ctrl.regWrite = 1'b1;
               ctrl.wdControl = 1'b1;
               nextState = S_FETCH;
            end
            S_MEM_WR: begin
               ctrl.iOrD = 1'b1;
               ctrl.memWrite = 1'b1;
               if (mem_ready)
                  nextState = S_FETCH;
               else if (timeout)
                  nextState = S_TRAP;
            end
            S_BRANCH: begin
               ctrl.aluSrcA = 1'b1;
               ctrl.aluSrcB = SRCB_RT;
               ctrl.aluControl = ALU_SUB;
               ctrl.pcSource = PCSRC_ALUOUT;
               ctrl.pcWrite = zero;
               nextState = S_FETCH;
            end
            S_JUMP: begin
               ctrl.pcWrite = 1'b1;
               ctrl.pcSource = PCSRC_JUMP;
               nextState = S_FETCH;
            end
            S_TRAP: nextState = S_TRAP;
            default: nextState = S_TRAP;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         armed <= 1'b0;
         illegal <= 1'b0;
         bus_error <= 1'b0;
      end else begin
         state <= nextState;
         armed <= 1'b1;
         if (armed && state == S_DECODE
             && nextState == S_TRAP)
            illegal <= 1'b1;
         if (timeout)
            bus_error <= 1'b1;
      end
   end

   assign mem_req = ctrl.memReq;
   assign mem_write = ctrl.memWrite;
   assign i_or_d = ctrl.iOrD;
   assign ir_write = ctrl.irWrite;
   assign pc_write = ctrl.pcWrite;
   assign pc_source = ctrl.pcSource;
   assign reg_write = ctrl.regWrite;
   assign wa_control = ctrl.waControl;
   assign wd_control = ctrl.wdControl;
   assign alu_src_a = ctrl.aluSrcA;
   assign alu_src_b = ctrl.aluSrcB;
   assign alu_control = ctrl.aluControl;
   assign sign_ext_signal = ctrl.signExt;
   assign busy_state = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multi-cycle control FSM with
// hand-computed expected states and enables.
module tb_multicycle_control_unit;

   localparam logic [3:0] ST_FETCH = 4'd0;
   localparam logic [3:0] ST_DEC   = 4'd1;
   localparam logic [3:0] ST_EXR   = 4'd2;
   localparam logic [3:0] ST_WBR   = 4'd3;
   localparam logic [3:0] ST_EXI   = 4'd4;
   localparam logic [3:0] ST_WBI   = 4'd5;
   localparam logic [3:0] ST_MADR  = 4'd6;
   localparam logic [3:0] ST_MWR   = 4'd9;
   localparam logic [3:0] ST_BR    = 4'd10;
   localparam logic [3:0] ST_JMP   = 4'd11;
   localparam logic [3:0] ST_TRAP  = 4'd12;
   localparam logic [3:0] A_NONE   = 4'b0000;
   localparam logic [3:0] A_ADD    = 4'b0010;
   localparam logic [3:0] A_SUB    = 4'b0110;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] funcode;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_write;
   logic       i_or_d;
   logic       ir_write;
   logic       pc_write;
   logic [1:0] pc_source;
   logic       reg_write;
   logic       wa_control;
   logic       wd_control;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [3:0] alu_control;
   logic [1:0] sign_ext_signal;
   logic       illegal;
   logic       bus_error;
   logic [3:0] busy_state;

   int nCmp = 0;
   int nBad = 0;
   int irCnt;
   logic memSeen;
   int lwSeq [11] = '{0, 0, 0, 0, 1, 6, 7, 7, 7, 7, 8};

   multicycle_control_unit dut (
      .clk             (clk),
      .rst             (rst),
      .opcode          (opcode),
      .funcode         (funcode),
      .zero            (zero),
      .mem_ready       (mem_ready),
      .mem_req         (mem_req),
      .mem_write       (mem_write),
      .i_or_d          (i_or_d),
      .ir_write        (ir_write),
      .pc_write        (pc_write),
      .pc_source       (pc_source),
      .reg_write       (reg_write),
      .wa_control      (wa_control),
      .wd_control      (wd_control),
      .alu_src_a       (alu_src_a),
      .alu_src_b       (alu_src_b),
      .alu_control     (alu_control),
      .sign_ext_signal (sign_ext_signal),
      .illegal         (illegal),
      .bus_error       (bus_error),
      .busy_state      (busy_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      nCmp++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Runs FETCH (ready) and DECODE, leaving the bench
   // at the start of the dispatched state.
   task automatic toExec(
      input logic [5:0] op,
      input logic [5:0] fn
   );
      opcode = op;
      funcode = fn;
      mem_ready = 1'b1;
      #1;
      check("fetch_st", busy_state, ST_FETCH);
      check("fetch_irw", ir_write, 1);
      tick();
      #1;
      check("decode_st", busy_state, ST_DEC);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      opcode = '0;
      funcode = '0;
      zero = 1'b0;
      mem_ready = 1'b0;
      tick();
      #1;
      check("rst_st", busy_state, ST_FETCH);
      check("rst_req", mem_req, 0);
      check("rst_alu", alu_control, A_NONE);
      check("rst_ill", illegal, 0);
      check("rst_berr", bus_error, 0);
      rst = 1'b0;
      tick();

      // add $3,$1,$2
      toExec(6'b000000, 6'b100000);
      #1;
      check("add_st", busy_state, ST_EXR);
      check("add_alu", alu_control, A_ADD);
      check("add_srca", alu_src_a, 1);
      check("add_rw3", reg_write, 0);
      tick();
      #1;
      check("add_wb", busy_state, ST_WBR);
      check("add_rw4", reg_write, 1);
      check("add_wa", wa_control, 1);
      tick();

      // lw with 3 wait cycles in FETCH and MEM_RD
      opcode = 6'b100011;
      funcode = '0;
      irCnt = 0;
      for (int k = 0; k < 11; k++) begin
         mem_ready = (k == 3) || (k == 9);
         #1;
         check($sformatf("lw_st%0d", k),
               busy_state, lwSeq[k]);
         irCnt += int'(ir_write);
         if (k == 6) check("lw_iord", i_or_d, 1);
         if (k == 10) check("lw_wd", wd_control, 1);
         tick();
      end
      #1;
      check("lw_done", busy_state, ST_FETCH);
      check("lw_irw", irCnt, 1);

      // beq taken then not taken
      toExec(6'b000100, 6'b000000);
      zero = 1'b1;
      #1;
      check("beq1_st", busy_state, ST_BR);
      check("beq1_pcw", pc_write, 1);
      check("beq1_psrc", pc_source, 2'b01);
      check("beq1_alu", alu_control, A_SUB);
      tick();
      toExec(6'b000100, 6'b000000);
      zero = 1'b0;
      #1;
      check("beq0_pcw", pc_write, 0);
      check("beq0_psrc", pc_source, 2'b01);
      tick();

      // lui
      toExec(6'b001111, 6'b000000);
      #1;
      check("lui_st", busy_state, ST_EXI);
      check("lui_ext", sign_ext_signal, 2'b10);
      check("lui_srcb", alu_src_b, 2'b10);
      tick();
      #1;
      check("lui_wb", busy_state, ST_WBI);
      check("lui_rw", reg_write, 1);
      check("lui_wa", wa_control, 0);
      tick();

      // j
      toExec(6'b000010, 6'b000000);
      #1;
      check("j_st", busy_state, ST_JMP);
      check("j_pcw", pc_write, 1);
      check("j_psrc", pc_source, 2'b10);
      tick();
      #1;
      check("j_done", busy_state, ST_FETCH);

      // sw, reset while the write is stalled
      toExec(6'b101011, 6'b000000);
      mem_ready = 1'b0;
      #1;
      check("sw_addr", busy_state, ST_MADR);
      tick();
      #1;
      check("sw_st", busy_state, ST_MWR);
      check("sw_mw", mem_write, 1);
      check("sw_req", mem_req, 1);
      tick();
      rst = 1'b1;
      tick();
      #1;
      check("swrst_req", mem_req, 0);
      check("swrst_mw", mem_write, 0);
      check("swrst_st", busy_state, ST_FETCH);
      rst = 1'b0;
      tick();

      // FETCH never answered
      for (int w = 1; w <= 16; w++) begin
         if (w == 16) begin
            #1;
            check("to_wait", busy_state, ST_FETCH);
            check("to_early", bus_error, 0);
         end
         tick();
      end
      #1;
      check("to_st", busy_state, ST_TRAP);
      check("to_berr", bus_error, 1);
      check("to_req", mem_req, 0);
      check("to_ill", illegal, 0);
      rst = 1'b1;
      tick();
      #1;
      check("to_clr", bus_error, 0);
      rst = 1'b0;
      tick();

      // undefined opcode
      toExec(6'b111111, 6'b000000);
      #1;
      check("ill_st", busy_state, ST_TRAP);
      check("ill_flag", illegal, 1);
      memSeen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         memSeen |= mem_req;
         tick();
      end
      check("ill_noreq", memSeen, 0);
      check("ill_hold", illegal, 1);
      check("ill_st2", busy_state, ST_TRAP);
      rst = 1'b1;
      tick();
      #1;
      check("ill_clr", illegal, 0);
      check("ill_rst", busy_state, ST_FETCH);
      rst = 1'b0;
      tick();

      // R-type with unsupported funct
      toExec(6'b000000, 6'b100010);
      #1;
      check("rbad_st", busy_state, ST_TRAP);
      check("rbad_ill", illegal, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               nCmp, nBad);
      $finish;
   end

endmodule
